fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter STEP, default 4: byte increment applied to PC on a sequential fetch.
REQ-002 Parameter CNT_W, default 16: width of the fetch counter.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low; low clears all state immediately.
REQ-005 pc_q  input  32  current PC value from the program counter register.
REQ-006 pc_d  output  32  next PC value driven to the program counter register.
REQ-007 pc_en  output  1  program counter load enable; one-cycle pulse per PC update.
REQ-008 imem_req  output  1  instruction memory read request.
REQ-009 imem_addr  output  32  instruction memory word address.
REQ-010 imem_ack  input  1  memory read completion; imem_rdata valid in the same cycle.
REQ-011 imem_rdata  input  32  instruction word returned by memory.
REQ-012 branch_taken  input  1  one-cycle redirect request from execute.
REQ-013 branch_target  input  32  redirect address, sampled when branch_taken=1.
REQ-014 stall  input  1  decode not ready; high holds the presented instruction.
REQ-015 instr_valid  output  1  instr/instr_pc hold a fetched instruction.
REQ-016 instr  output  32  fetched instruction word.
REQ-017 instr_pc  output  32  address the instruction was fetched from.
REQ-018 misalign_err  output  1  sticky flag: a branch target with bits[1:0]!=0 was received.
REQ-019 fetch_count  output  CNT_W  number of instructions delivered to decode; wraps modulo 2^CNT_W.

Function
REQ-020 FSM states: IDLE, REQ, VALID; exactly one state active at all times.
REQ-021 IDLE: held for exactly one cycle after reset deasserts, then moves to REQ.
REQ-022 REQ: imem_req=1 and imem_addr=pc_q combinationally; remains in REQ until imem_ack=1.
REQ-023 imem_req and imem_addr are held stable from request until ack; at most one request is outstanding.
REQ-024 On ack in REQ with no kill pending: in the same cycle, pc_en=1 and pc_d=pc_q+STEP, with 32-bit wrap (0xFFFFFFFC+4=0).
REQ-025 Same ack edge: instr<=imem_rdata, instr_pc<=pc_q, instr_valid<=1, and state moves to VALID.
REQ-026 VALID: imem_req=0; instr, instr_pc and instr_valid are held while stall=1.
REQ-027 VALID with stall=0: the instruction is consumed that cycle; fetch_count increments by 1, instr_valid<=0 and state moves to REQ (one bubble cycle per instruction).
REQ-028 branch_taken in any non-IDLE state: same cycle pc_en=1, pc_d={branch_target[31:2],2'b00}; branch takes priority over a sequential increment in the same cycle.
REQ-029 branch_taken in VALID: instr_valid<=0, fetch_count is not incremented, state moves to REQ.
REQ-030 branch_taken in REQ with no ack that cycle: sets kill; the next ack is discarded (no capture, no pc_en), then state stays REQ and refetches from the new pc_q.
REQ-031 branch_taken and ack in the same REQ cycle: rdata is discarded, no kill is set, and state stays REQ.
REQ-032 branch_target[1:0]!=0 with branch_taken=1: misalign_err<=1, held until reset.
REQ-033 branch_taken in IDLE: ignored.
REQ-034 pc_en=0 in every cycle not covered by REQ-024 or REQ-028; pc_d=pc_q+STEP when pc_en=0.

Reset
REQ-035 reset=0: asynchronously force state=IDLE, instr_valid=0, instr=0, instr_pc=0, kill=0, misalign_err=0, fetch_count=0; imem_req=0 and pc_en=0.
REQ-036 Reset asserted mid-request: the outstanding request is abandoned, and an ack arriving after release while in IDLE is ignored.
REQ-037 Reset release is synchronised internally to clk; the first REQ occurs in the 2nd rising edge after release.

Verification
REQ-038 Sequential fetch: pc_q=0, ack after 1 cycle, words A,B,C, stall=0 -> instr A@0, B@4, C@8; pc_en pulses with pc_d 4, 8, 12; fetch_count=3.
REQ-039 Stall: assert stall for 5 cycles in VALID -> instr/instr_pc constant, imem_req=0, no pc_en, fetch_count unchanged.
REQ-040 Branch during wait: branch_taken, target=0x100, while awaiting ack from 0x8 -> stale ack discarded, next request addr=0x100, next delivered instr_pc=0x100.
REQ-041 Branch+ack same cycle plus misaligned target 0x203 -> pc_d=0x200, misalign_err=1 sticky, data from the old address never delivered.
REQ-042 Wrap: pc_q=0xFFFFFFFC ack -> pc_d=0; with CNT_W=4, the 16th delivery -> fetch_count=0.
REQ-043 Async reset mid-REQ, between edges -> outputs clear immediately; a late ack after release is ignored; first request resumes from pc_q.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch FSM with branch redirect, kill of stale responses and stall hold.
module fetch_unit #(
  parameter int unsigned STEP  = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc_q,
  output logic [31:0]      pc_d,
  output logic             pc_en,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             stall,
  output logic             instr_valid,
  output logic [31:0]      instr,
  output logic [31:0]      instr_pc,
  output logic             misalign_err,
  output logic [CNT_W-1:0] fetch_count
);
  typedef enum logic [1:0] {IDLE, REQ, VALID} state_t;
  state_t            state_q, state_d;
  logic              rst_sync_q;
  logic              valid_q, valid_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       ipc_q, ipc_d;
  logic              kill_q, kill_d;
  logic              mis_q, mis_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              br, seq;
  // rst_sync_q holds IDLE for one edge after release so the first request lands on the 2nd edge
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rst_sync_q <= 1'b0;
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      ipc_q      <= '0;
      kill_q     <= 1'b0;
      mis_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      rst_sync_q <= 1'b1;
      state_q    <= state_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      ipc_q      <= ipc_d;
      kill_q     <= kill_d;
      mis_q      <= mis_d;
      cnt_q      <= cnt_d;
    end
  always_comb begin
    br        = branch_taken && state_q != IDLE;
    seq       = state_q == REQ && imem_ack && !kill_q;
    pc_en     = br || seq;
    pc_d      = br ? {branch_target[31:2], 2'b00} : pc_q + 32'(STEP);
    imem_req  = state_q == REQ;
    imem_addr = pc_q;
    state_d   = state_q;
    valid_d   = valid_q;
    instr_d   = instr_q;
    ipc_d     = ipc_q;
    kill_d    = kill_q;
    cnt_d     = cnt_q;
    mis_d     = mis_q | (br && |branch_target[1:0]);
    if (state_q == IDLE) begin
      state_d = rst_sync_q ? REQ : IDLE;
    end else if (state_q == REQ) begin
      if (imem_ack) begin
        kill_d = 1'b0;
        // a redirect in the ack cycle discards the returned word
        if (seq && !branch_taken) begin
          instr_d = imem_rdata;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          state_d = VALID;
        end
      end else if (branch_taken) begin
        kill_d = 1'b1;
      end
    end else if (branch_taken || !stall) begin
      valid_d = 1'b0;
      state_d = REQ;
      cnt_d   = branch_taken ? cnt_q : cnt_q + 1'b1;
    end
  end
  assign instr_valid  = valid_q;
  assign instr        = instr_q;
  assign instr_pc     = ipc_q;
  assign misalign_err = mis_q;
  assign fetch_count  = cnt_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenario tests for fetch_unit with a bench-side PC register.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_r, pc_d;
  logic        pc_en, imem_req, imem_ack, branch_taken, stall, instr_valid, misalign_err;
  logic [31:0] imem_addr, imem_rdata, branch_target, instr, instr_pc;
  logic [3:0]  fetch_count;
  logic        pc_ld;
  logic [31:0] pc_ld_val;
  int passed = 0;
  int total  = 0;

  fetch_unit #(.STEP(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .pc_q(pc_r), .pc_d(pc_d), .pc_en(pc_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .branch_taken(branch_taken), .branch_target(branch_target), .stall(stall),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .misalign_err(misalign_err), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // program counter register living outside the fetch unit
  always @(posedge clk)
    if (pc_en) pc_r <= pc_d;
    else if (pc_ld) pc_r <= pc_ld_val;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    pc_ld = 1'b1; pc_ld_val = 32'h0;
    tick; tick;
    pc_ld = 1'b0;
    total++; if ({imem_req, pc_en, instr_valid, misalign_err} !== 4'b0) $display("FAIL reset_ctrl got %b want 0000", {imem_req, pc_en, instr_valid, misalign_err}); else passed++;
    total++; if ({instr, instr_pc, fetch_count} !== 68'h0) $display("FAIL reset_data got %h/%h/%h want 0", instr, instr_pc, fetch_count); else passed++;
    #2 reset = 1'b1;
    tick;
    total++; if (imem_req !== 1'b0) $display("FAIL idle_hold got %b want 0", imem_req); else passed++;
    branch_taken = 1'b1; branch_target = 32'h13;
    #1;
    total++; if (pc_en !== 1'b0) $display("FAIL idle_branch_pc_en got %b want 0", pc_en); else passed++;
    tick;
    branch_taken = 1'b0;
    total++; if ({imem_req, misalign_err, imem_addr} !== {2'b10, 32'h0}) $display("FAIL first_req got req=%b mis=%b addr=%h want 1 0 0", imem_req, misalign_err, imem_addr); else passed++;
  endtask

  task automatic test_sequential;
    logic [31:0] w [3] = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003};
    for (int i = 0; i < 3; i++) begin
      tick;
      total++; if ({imem_req, imem_addr} !== {1'b1, 32'(4*i)}) $display("FAIL seq_req%0d got %b %h want 1 %h", i, imem_req, imem_addr, 4*i); else passed++;
      imem_ack = 1'b1; imem_rdata = w[i];
      #1;
      total++; if ({pc_en, pc_d} !== {1'b1, 32'(4*(i+1))}) $display("FAIL seq_pc%0d got %b %h want 1 %h", i, pc_en, pc_d, 4*(i+1)); else passed++;
      tick;
      imem_ack = 1'b0;
      total++; if ({instr_valid, instr, instr_pc} !== {1'b1, w[i], 32'(4*i)}) $display("FAIL seq_instr%0d got %b %h @%h want 1 %h @%h", i, instr_valid, instr, instr_pc, w[i], 4*i); else passed++;
      total++; if (imem_req !== 1'b0) $display("FAIL seq_valid_req%0d got %b want 0", i, imem_req); else passed++;
      tick;
    end
    total++; if ({fetch_count, imem_req, imem_addr} !== {4'd3, 1'b1, 32'hC}) $display("FAIL seq_end got cnt=%0d req=%b addr=%h want 3 1 c", fetch_count, imem_req, imem_addr); else passed++;
  endtask

  task automatic test_stall;
    imem_ack = 1'b1; imem_rdata = 32'hD00D_0004;
    tick;
    imem_ack = 1'b0; stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if ({imem_req, pc_en} !== 2'b00) $display("FAIL stall_ctrl%0d got %b want 00", i, {imem_req, pc_en}); else passed++;
      tick;
      total++; if ({instr_valid, instr, instr_pc, fetch_count} !== {1'b1, 32'hD00D_0004, 32'hC, 4'd3}) $display("FAIL stall_hold%0d got %b %h @%h cnt=%0d", i, instr_valid, instr, instr_pc, fetch_count); else passed++;
    end
    stall = 1'b0;
    tick;
    total++; if ({instr_valid, fetch_count} !== {1'b0, 4'd4}) $display("FAIL stall_release got %b cnt=%0d want 0 4", instr_valid, fetch_count); else passed++;
  endtask

  task automatic test_branch_wait;
    branch_taken = 1'b1; branch_target = 32'h100;
    #1;
    total++; if ({pc_en, pc_d} !== {1'b1, 32'h100}) $display("FAIL bw_pc got %b %h want 1 100", pc_en, pc_d); else passed++;
    tick;
    branch_taken = 1'b0;
    total++; if ({imem_req, imem_addr} !== {1'b1, 32'h100}) $display("FAIL bw_addr got %b %h want 1 100", imem_req, imem_addr); else passed++;
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0010;
    #1;
    total++; if (pc_en !== 1'b0) $display("FAIL bw_stale_pc_en got %b want 0", pc_en); else passed++;
    tick;
    imem_ack = 1'b0;
    total++; if ({instr_valid, imem_req} !== 2'b01) $display("FAIL bw_stale got valid=%b req=%b want 0 1", instr_valid, imem_req); else passed++;
    imem_ack = 1'b1; imem_rdata = 32'h600D_0100;
    #1;
    total++; if ({pc_en, pc_d} !== {1'b1, 32'h104}) $display("FAIL bw_refetch_pc got %b %h want 1 104", pc_en, pc_d); else passed++;
    tick;
    imem_ack = 1'b0;
    total++; if ({instr_valid, instr, instr_pc} !== {1'b1, 32'h600D_0100, 32'h100}) $display("FAIL bw_instr got %b %h @%h want 1 600d0100 @100", instr_valid, instr, instr_pc); else passed++;
    tick;
    total++; if (fetch_count !== 4'd5) $display("FAIL bw_count got %0d want 5", fetch_count); else passed++;
  endtask

  task automatic test_branch_ack_misalign;
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0104; branch_taken = 1'b1; branch_target = 32'h203;
    #1;
    total++; if ({pc_en, pc_d} !== {1'b1, 32'h200}) $display("FAIL ba_pc got %b %h want 1 200", pc_en, pc_d); else passed++;
    tick;
    imem_ack = 1'b0; branch_taken = 1'b0;
    total++; if ({misalign_err, instr_valid, imem_req, imem_addr} !== {3'b101, 32'h200}) $display("FAIL ba_state got mis=%b valid=%b req=%b addr=%h", misalign_err, instr_valid, imem_req, imem_addr); else passed++;
    imem_ack = 1'b1; imem_rdata = 32'h600D_0200;
    tick;
    imem_ack = 1'b0;
    total++; if ({instr, instr_pc} !== {32'h600D_0200, 32'h200}) $display("FAIL ba_instr got %h @%h want 600d0200 @200", instr, instr_pc); else passed++;
    branch_taken = 1'b1; branch_target = 32'h300;
    #1;
    total++; if ({pc_en, pc_d} !== {1'b1, 32'h300}) $display("FAIL bv_pc got %b %h want 1 300", pc_en, pc_d); else passed++;
    tick;
    branch_taken = 1'b0;
    total++; if ({instr_valid, fetch_count, misalign_err, imem_req} !== {1'b0, 4'd5, 2'b11}) $display("FAIL bv_state got valid=%b cnt=%0d mis=%b req=%b", instr_valid, fetch_count, misalign_err, imem_req); else passed++;
  endtask

  task automatic test_wrap;
    pc_ld = 1'b1; pc_ld_val = 32'hFFFF_FFFC;
    tick;
    pc_ld = 1'b0;
    total++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr got %h want fffffffc", imem_addr); else passed++;
    imem_ack = 1'b1; imem_rdata = 32'h0000_00FF;
    #1;
    total++; if ({pc_en, pc_d} !== {1'b1, 32'h0}) $display("FAIL wrap_pc got %b %h want 1 0", pc_en, pc_d); else passed++;
    tick;
    imem_ack = 1'b0;
    tick;
    for (int i = 0; i < 9; i++) begin
      imem_ack = 1'b1; tick; imem_ack = 1'b0; tick;
    end
    total++; if (fetch_count !== 4'd15) $display("FAIL cnt_15 got %0d want 15", fetch_count); else passed++;
    imem_ack = 1'b1; tick; imem_ack = 1'b0; tick;
    total++; if (fetch_count !== 4'd0) $display("FAIL cnt_wrap got %0d want 0", fetch_count); else passed++;
  endtask

  task automatic test_async_reset;
    imem_ack = 1'b1; tick; imem_ack = 1'b0; tick;
    total++; if ({fetch_count, misalign_err, imem_addr} !== {4'd1, 1'b1, 32'h2C}) $display("FAIL ar_pre got cnt=%0d mis=%b addr=%h want 1 1 2c", fetch_count, misalign_err, imem_addr); else passed++;
    #2 reset = 1'b0;
    #1;
    total++; if ({imem_req, pc_en, instr_valid, misalign_err, fetch_count} !== 8'h0) $display("FAIL ar_clear got req=%b en=%b valid=%b mis=%b cnt=%0d", imem_req, pc_en, instr_valid, misalign_err, fetch_count); else passed++;
    tick;
    #2 reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hBAD0_002C;
    tick;
    total++; if ({pc_en, instr_valid, imem_req} !== 3'b000) $display("FAIL ar_late_ack got en=%b valid=%b req=%b want 000", pc_en, instr_valid, imem_req); else passed++;
    imem_ack = 1'b0;
    tick;
    total++; if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h2C, 1'b0}) $display("FAIL ar_resume got req=%b addr=%h valid=%b", imem_req, imem_addr, instr_valid); else passed++;
    imem_ack = 1'b1; imem_rdata = 32'h600D_002C;
    tick;
    imem_ack = 1'b0;
    total++; if ({instr, instr_pc, fetch_count} !== {32'h600D_002C, 32'h2C, 4'd0}) $display("FAIL ar_fetch got %h @%h cnt=%0d", instr, instr_pc, fetch_count); else passed++;
  endtask

  initial begin
    reset = 1'b0; imem_ack = 1'b0; imem_rdata = '0; branch_taken = 1'b0;
    branch_target = '0; stall = 1'b0; pc_ld = 1'b0; pc_ld_val = '0;
    test_reset;
    test_sequential;
    test_stall;
    test_branch_wait;
    test_branch_ack_misalign;
    test_wrap;
    test_async_reset;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
